demux_1x4_reg: RTL and testbench
================================

Name: demux_1x4_reg

Overview:
Registered 1-to-4 demultiplexer, the distributing counterpart of the team's 4:1 mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input port.
- Routes each word, under a 2-bit select, into one of four independent output channels.
- Each output channel holds one entry and has its own valid/ready handshake.
- Used wherever a shared bus must fan out to four consumers with backpressure.

Parameters:
WIDTH, 2, data width of input and each output channel
CNT_W, 8, width of the accepted-transfer counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_data  input  WIDTH  input word
in_sel  input  2  destination channel (0..3) for in_data
in_valid  input  1  input word present
in_ready  output  1  block can accept the word addressed by in_sel this cycle
out0_data  output  WIDTH  channel 0 data
out1_data  output  WIDTH  channel 1 data
out2_data  output  WIDTH  channel 2 data
out3_data  output  WIDTH  channel 3 data
out_valid  output  4  per-channel valid, bit n = channel n
out_ready  input  4  per-channel consumer ready, bit n = channel n
xfer_cnt  output  CNT_W  count of accepted input words

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 4'b0000.
  - out0..3_data = 0.
  - xfer_cnt = 0.
  - Any held words are discarded.
  - in_ready follows its combinational definition, so it reads 1 during reset. Words presented while rst=1 are not captured.
- Per-channel state, 2 states:
  - EMPTY (out_valid[n]=0) and FULL (out_valid[n]=1).
  - EMPTY→FULL on accept to n.
  - FULL→EMPTY on out_ready[n]=1 with no accept to n.
  - FULL→FULL when out_ready[n]=0, or when out_ready[n]=1 and an accept to n occur in the same cycle.
- in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - Purely combinational; no other gating.
  - Full-throughput pass-through when the consumer is ready.
- Accept = in_valid && in_ready.
  - On accept, outN_data for N=in_sel is loaded with in_data at the next rising edge, and out_valid[N] becomes 1.
  - Latency: 1 cycle from accept to out_valid.
- Output transfer on channel n = out_valid[n] && out_ready[n].
  - Clears out_valid[n] unless an accept to n happens in the same cycle. In that case the new word replaces the old one and valid stays 1 (no bubble).
- Data hold:
  - outN_data changes only on accept to N; it is not cleared on drain.
  - While out_valid[n]=1 and out_ready[n]=0, outN_data and out_valid[n] are stable.
- Channels are independent:
  - A stalled channel never blocks a word addressed to another channel.
  - out_ready of a non-selected channel has no effect on in_ready.
- Sender rule: while in_valid=1 and in_ready=0, in_data and in_sel must stay stable. The bench checks this with an assertion; the RTL does not detect violations.
- in_valid=0: no state change except drains. in_sel and in_data are don't-care.
- xfer_cnt increments by 1 on each accept and wraps 2^CNT_W-1 → 0 with no flag.
- Reset asserted mid-transfer:
  - Outputs go to reset values immediately (asynchronously).
  - The first accept is possible on the first rising edge after rst deasserts.

Test Plan:
- Reset check: assert rst mid-stream with channels FULL → out_valid=0000, all outN_data=00, xfer_cnt=0 immediately; first word after release lands 1 cycle later.
- Routing sweep: all out_ready=1; send data 00,01,10,11 with in_sel 0,1,2,3 on consecutive cycles.
  - Required: out0=00, out1=01, out2=10, out3=11.
  - Each valid pulses exactly 1 cycle, 1 cycle after its accept; xfer_cnt=4.
- Backpressure: out_ready[2]=0; send 10 to ch2, then 11 to ch2.
  - Required: in_ready=0 on the second word; out2_data holds 10 with out_valid[2]=1.
  - Raising out_ready[2] accepts 11 on that edge and out2_data becomes 11 next cycle with no valid gap.
- Independence: ch1 stalled and FULL; send 01 to ch3 → accepted immediately, out3_data=01, ch1 unchanged.
- Streaming replace: ch0 out_ready=1; 8 back-to-back words to ch0 → in_ready stays 1, out_valid[0] stays 1 throughout, every word observed in order.
- Counter wrap: with CNT_W=8, 256 accepts → xfer_cnt returns to 0; 257th accept → xfer_cnt=1.

Source files
------------

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer: one valid/ready input fanned out to four
// single-entry output channels, each with its own valid/ready handshake.
module demux_1x4_reg #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [3:0][WIDTH-1:0] data_q, data_d;
    logic [3:0]            valid_q, valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    // A FULL channel whose consumer is ready can take a new word in the same
    // cycle it drains, so streaming into one channel never bubbles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        in_ready = !valid_q[in_sel] || out_ready[in_sel];
        accept   = in_valid && in_ready;
        data_d   = data_q;
        valid_d  = valid_q & ~out_ready;
        cnt_d    = cnt_q;
        if (accept) begin
            data_d[in_sel]  = in_data;
            valid_d[in_sel] = 1'b1;
            cnt_d           = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data registers are reset too, because their zero value is visible on the ports.
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];
    assign out_valid = valid_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Self-checking bench for demux_1x4_reg: directed steps with a per-channel
// scoreboard of words pushed on accept and popped when the consumer drains.
module tb_demux_1x4_reg;

    localparam int WIDTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] xfer_cnt;

    always #5 clk = ~clk;

    demux_1x4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    logic [WIDTH-1:0] od [4];
    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;

    logic [WIDTH-1:0] exp_q [4][$];
    logic [WIDTH-1:0] last_d [4];
    logic [CNT_W-1:0] m_cnt;
    logic             hold_pend;
    logic [1:0]       hold_sel;
    logic [WIDTH-1:0] hold_data;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int n = 0; n < 4; n++) begin
            exp_q[n].delete();
            last_d[n] = '0;
        end
        m_cnt     = '0;
        hold_pend = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("%s valid%0d", tag, n), 32'(out_valid[n]), 32'(exp_q[n].size() != 0));
            if (exp_q[n].size() != 0)
                chk($sformatf("%s data%0d", tag, n), 32'(od[n]), 32'(exp_q[n][0]));
            else
                chk($sformatf("%s hold%0d", tag, n), 32'(od[n]), 32'(last_d[n]));
        end
        chk({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    endtask

    // One clock of stimulus: drive, check in_ready, advance, update scoreboard, check outputs.
    task automatic step(input string tag, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] rdy);
        logic exp_rdy;
        logic acc;
        if (hold_pend)
            chk({tag, " sender_hold"}, 32'({v, s, d}), 32'({1'b1, hold_sel, hold_data}));
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        #1;
        exp_rdy = (exp_q[s].size() == 0) || rdy[s];
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc       = v && exp_rdy;
        hold_pend = v && !exp_rdy;
        hold_sel  = s;
        hold_data = d;
        @(posedge clk);
        for (int n = 0; n < 4; n++)
            if (exp_q[n].size() != 0 && rdy[n]) void'(exp_q[n].pop_front());
        if (acc) begin
            exp_q[s].push_back(d);
            last_d[s] = d;
            m_cnt     = m_cnt + CNT_W'(1);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 2'b01;
        #1;
        reset_model();
        check_outputs({tag, " async"});
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_outputs({tag, " held"});
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        reset_model();
        @(posedge clk);
        #1;
        check_outputs("por");
        #2;
        rst = 1'b0;

        // Routing sweep with all consumers ready
        step("route0", 1'b1, 2'd0, 2'b00, 4'b1111);
        step("route1", 1'b1, 2'd1, 2'b01, 4'b1111);
        step("route2", 1'b1, 2'd2, 2'b10, 4'b1111);
        step("route3", 1'b1, 2'd3, 2'b11, 4'b1111);
        step("route_idle", 1'b0, 2'd0, 2'b00, 4'b1111);
        chk("route_cnt", 32'(xfer_cnt), 32'd4);

        // Backpressure on channel 2
        step("bp_first", 1'b1, 2'd2, 2'b10, 4'b1011);
        step("bp_stall_a", 1'b1, 2'd2, 2'b11, 4'b1011);
        step("bp_stall_b", 1'b1, 2'd2, 2'b11, 4'b1011);
        chk("bp_held_data", 32'(out2_data), 32'(2'b10));
        step("bp_release", 1'b1, 2'd2, 2'b11, 4'b1111);
        chk("bp_no_gap", 32'(out_valid[2]), 32'd1);
        step("bp_drain", 1'b0, 2'd0, 2'b00, 4'b1111);

        // Independence: channel 1 stalled, channel 3 still flows
        step("ind_fill", 1'b1, 2'd1, 2'b01, 4'b1101);
        step("ind_ch3", 1'b1, 2'd3, 2'b01, 4'b1101);
        chk("ind_ch3_data", 32'(out3_data), 32'(2'b01));
        step("ind_ch1_stall", 1'b1, 2'd1, 2'b10, 4'b1101);
        step("ind_release", 1'b1, 2'd1, 2'b10, 4'b1111);
        step("ind_drain", 1'b0, 2'd0, 2'b00, 4'b1111);

        // Streaming replace into channel 0
        for (int i = 0; i < 8; i++)
            step($sformatf("stream%0d", i), 1'b1, 2'd0, 2'(i ^ (i >> 2)), 4'b1111);
        step("stream_drain", 1'b0, 2'd0, 2'b00, 4'b1111);

        // Reset while every channel is FULL
        step("rf0", 1'b1, 2'd0, 2'b11, 4'b0000);
        step("rf1", 1'b1, 2'd1, 2'b10, 4'b0000);
        step("rf2", 1'b1, 2'd2, 2'b01, 4'b0000);
        step("rf3", 1'b1, 2'd3, 2'b11, 4'b0000);
        pulse_reset("rst_mid");
        step("rst_first", 1'b1, 2'd2, 2'b01, 4'b0000);
        chk("rst_first_valid", 32'(out_valid), 32'(4'b0100));
        step("rst_drain", 1'b0, 2'd0, 2'b00, 4'b1111);

        // Counter wrap
        pulse_reset("rst_wrap");
        for (int i = 0; i < 256; i++)
            step("wrap", 1'b1, 2'(i), 2'(i >> 2), 4'b1111);
        chk("wrap256", 32'(xfer_cnt), 32'd0);
        step("wrap257", 1'b1, 2'd0, 2'b01, 4'b1111);
        chk("wrap257_cnt", 32'(xfer_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
